// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the push-button debounce / pulse block.
//   btn_state_t  - debouncer FSM state encoding
//   SYNC_STAGES  - depth of the input synchroniser
//   cnt_width()  - width of a counter that must hold values 0..n-1
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int SYNC_STAGES = 2;

  // Never returns zero so that a counter declared with it always has a bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: flop-chain synchroniser for a single asynchronous bit.
//   clk   - destination clock
//   rst   - asynchronous, active-high reset; clears every stage
//   d     - asynchronous input
//   q     - synchronised output, STAGES clock edges behind d
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
    end else begin
      sh <= {sh[STAGES-2:0], d};
    end
  end

  assign q = sh[STAGES-1];

endmodule

// File: rtl/btn_toggle_pulse.sv
// btn_toggle_pulse: debounces a raw push-button and emits one clock-wide
// pulse per qualified press, intended for the t input of a toggle flop.
//   clk      - system clock, rising edge
//   rst      - asynchronous, active-high reset
//   btn_in   - raw button, active-high, asynchronous, may bounce
//   pulse_o  - registered single-cycle press pulse
//   level_o  - registered debounced button level
// Parameters:
//   DEBOUNCE_CYCLES - stable samples beyond the first needed to accept a change (>= 2)
//   REPEAT_DELAY    - cycles in HELD before the first auto-repeat pulse
//   REPEAT_PERIOD   - cycles between subsequent auto-repeat pulses (>= 2)
// Build option:
//   BTN_TOGGLE_PULSE_REPEAT_EN - when defined, holding the button produces
//   auto-repeat pulses; otherwise the REPEAT_* parameters have no effect.
module btn_toggle_pulse
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse_o,
  output logic level_o
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt;
  logic             press_fire;
  logic             rpt_fire;

  sync_2ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  // Any bounce in a WAIT state drops straight back to the previous stable
  // state with the count cleared, so acceptance needs an unbroken run.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    level_nxt  = level_o;
    press_fire = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = HELD;
          cnt_nxt    = '0;
          press_fire = 1'b1;
          level_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      level_o <= 1'b0;
      pulse_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      level_o <= level_nxt;
      pulse_o <= press_fire | rpt_fire;
    end
  end

`ifdef BTN_TOGGLE_PULSE_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = cnt_width(RPT_MAX);

  logic [RPT_W-1:0] rpt;
  logic             rpt_armed;
  logic             rpt_run;

  // The repeat counter advances only on cycles that stay in HELD; a dip
  // into RELEASE_WAIT leaves it frozen so a bounce does not restart the
  // repeat schedule. rpt_armed separates the initial delay from the period.
  assign rpt_run = (state == HELD) && btn_s;

  always_comb begin
    rpt_fire = 1'b0;
    if (rpt_run) begin
      if (rpt_armed) begin
        rpt_fire = (rpt == RPT_W'(REPEAT_PERIOD - 1));
      end else begin
        rpt_fire = (rpt == RPT_W'(REPEAT_DELAY - 1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt       <= '0;
      rpt_armed <= 1'b0;
    end else if (state_nxt == IDLE) begin
      rpt       <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_run) begin
      if (rpt_fire) begin
        rpt       <= '0;
        rpt_armed <= 1'b1;
      end else begin
        rpt <= rpt + 1'b1;
      end
    end
  end
`else
  logic unused_rpt_params;

  assign rpt_fire          = 1'b0;
  assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

endmodule

// File: tb/tb_btn_toggle_pulse.sv
module tb_btn_toggle_pulse;

  logic clk;
  logic rst;
  logic btn_in;
  logic pulse_o;
  logic level_o;

  int checks;
  int failures;
  int pulse_cnt;
  logic level_seen_hi;
  logic level_seen_lo;
  int rpt_expect;

  btn_toggle_pulse #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .pulse_o (pulse_o),
    .level_o (level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive btn_in, wait for the next rising edge, then sample 1 ns later.
  task automatic step(input logic b);
    btn_in = b;
    @(posedge clk);
    #1;
    if (pulse_o === 1'b1) pulse_cnt++;
    if (level_o === 1'b1) level_seen_hi = 1'b1;
    if (level_o === 1'b0) level_seen_lo = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    pulse_cnt     = 0;
    level_seen_hi = 1'b0;
    level_seen_lo = 1'b0;
    rst           = 1'b1;
    btn_in        = 1'b0;

    // Reset state
    repeat (3) step(1'b0);
    chk("reset_pulse", 32'(pulse_o), 32'd0);
    chk("reset_level", 32'(level_o), 32'd0);
    rst = 1'b0;
    repeat (3) step(1'b0);

    // Clean press: capture at edge 0, outputs rise after edge 6
    pulse_cnt = 0;
    step(1'b1);                       // edge 0
    repeat (5) step(1'b1);            // edges 1..5
    chk("press_lvl_e5", 32'(level_o), 32'd0);
    chk("press_pcnt_e5", 32'(pulse_cnt), 32'd0);
    step(1'b1);                       // edge 6
    chk("press_pulse_e6", 32'(pulse_o), 32'd1);
    chk("press_lvl_e6", 32'(level_o), 32'd1);
    step(1'b1);                       // edge 7
    chk("press_pulse_e7", 32'(pulse_o), 32'd0);
    repeat (12) step(1'b1);
    chk("press_pcnt_end", 32'(pulse_cnt), 32'd1);
    chk("press_lvl_end", 32'(level_o), 32'd1);

    // Clean release: level falls after edge 6, no pulse
    step(1'b0);                       // edge 0
    repeat (5) step(1'b0);
    chk("rel_lvl_e5", 32'(level_o), 32'd1);
    step(1'b0);                       // edge 6
    chk("rel_lvl_e6", 32'(level_o), 32'd0);
    chk("rel_no_pulse", 32'(pulse_cnt), 32'd1);
    repeat (3) step(1'b0);

    // Bounce 1,0,1,0 then steady 1: last rising capture at e4, pulse at e10
    pulse_cnt = 0;
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);   // e0..e3
    step(1'b1);                                       // e4
    repeat (5) step(1'b1);                            // e5..e9
    chk("bnc_pcnt_e9", 32'(pulse_cnt), 32'd0);
    chk("bnc_lvl_e9", 32'(level_o), 32'd0);
    step(1'b1);                                       // e10
    chk("bnc_pulse_e10", 32'(pulse_o), 32'd1);
    chk("bnc_lvl_e10", 32'(level_o), 32'd1);
    repeat (4) step(1'b1);
    chk("bnc_pcnt_end", 32'(pulse_cnt), 32'd1);
    repeat (8) step(1'b0);
    chk("bnc_rel_lvl", 32'(level_o), 32'd0);

    // Short glitch: 3 cycles high is below the acceptance threshold
    pulse_cnt     = 0;
    level_seen_hi = 1'b0;
    repeat (3) step(1'b1);
    repeat (10) step(1'b0);
    chk("glitch_pcnt", 32'(pulse_cnt), 32'd0);
    chk("glitch_lvl_seen", 32'(level_seen_hi), 32'd0);

    // Release bounce: HELD, 2 cycles low, back high -> stays pressed
    repeat (8) step(1'b1);
    chk("rb_held_lvl", 32'(level_o), 32'd1);
    pulse_cnt     = 0;
    level_seen_lo = 1'b0;
    repeat (2) step(1'b0);
    repeat (8) step(1'b1);
    chk("rb_pcnt", 32'(pulse_cnt), 32'd0);
    chk("rb_lvl_no_drop", 32'(level_seen_lo), 32'd0);
    step(1'b0);                       // edge 0
    repeat (5) step(1'b0);
    chk("rb_rel_lvl_e5", 32'(level_o), 32'd1);
    step(1'b0);                       // edge 6
    chk("rb_rel_lvl_e6", 32'(level_o), 32'd0);
    chk("rb_rel_pcnt", 32'(pulse_cnt), 32'd0);
    repeat (3) step(1'b0);

    // Reset mid-press: btn held through reset, full debounce afterwards
    pulse_cnt = 0;
    repeat (4) step(1'b1);            // FSM now in PRESS_WAIT
    rst = 1'b1;
    step(1'b1);
    step(1'b1);
    chk("rstmid_lvl", 32'(level_o), 32'd0);
    chk("rstmid_pulse", 32'(pulse_o), 32'd0);
    rst = 1'b0;
    step(1'b1);                       // edge 0 after reset
    repeat (5) step(1'b1);
    chk("rstmid_pcnt_e5", 32'(pulse_cnt), 32'd0);
    step(1'b1);                       // edge 6
    chk("rstmid_pulse_e6", 32'(pulse_o), 32'd1);
    chk("rstmid_lvl_e6", 32'(level_o), 32'd1);

    // Asynchronous reset while HELD clears the level without a clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_lvl", 32'(level_o), 32'd0);
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    repeat (3) step(1'b0);

    // Long hold: 30 cycles after HELD
`ifdef BTN_TOGGLE_PULSE_REPEAT_EN
    rpt_expect = 8;                   // HELD+0,10,13,16,19,22,25,28
`else
    rpt_expect = 1;
`endif
    pulse_cnt = 0;
    repeat (7) step(1'b1);            // edges 0..6, HELD entered
    chk("hold_first_pulse", 32'(pulse_o), 32'd1);
    repeat (30) step(1'b1);
    chk("hold_pcnt", 32'(pulse_cnt), 32'(rpt_expect));
    repeat (8) step(1'b0);
    chk("hold_rel_lvl", 32'(level_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
